addsub_pipe: RTL and testbench
==============================

Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement add/subtract unit; generational successor to the fixed 16-bit ripple subtractor in the ALU datapath.
- Operand width is split into STAGES equal slices. One slice resolves per pipeline stage, and the carry is registered between stages, so clock frequency does not degrade with WIDTH.
- Valid/ready handshake on both sides; accepts one operation per cycle at full throughput. Per-operation add/sub mode; unsigned carry/borrow, signed overflow and zero flags.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and slice count; 1 ≤ STAGES ≤ WIDTH; slice width SW = WIDTH/STAGES.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- in_sub  in  1  1: a − b; 0: a + b
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  WIDTH  sum/difference, modulo 2^WIDTH
- out_cout  out  1  raw carry out of a + (b ^ {WIDTH{sub}}) + sub
- out_borrow  out  1  sub && !cout (unsigned a < b); 0 for add
- out_ovf  out  1  signed overflow
- out_zero  out  1  out_result == 0
- out_combine  out  WIDTH+1  {out_cout, out_result}

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, so out_valid=0. All data/flag registers 0, so out_result=0, out_cout=0, out_borrow=0, out_ovf=0, out_zero=0, out_combine=0.
- Global stall: advance = !out_valid || out_ready; in_ready = advance (combinational from out_ready). When !advance, every stage register holds.
- Stage 0, on accept: computes slice 0 as a[SW-1:0] + (b^sub)[SW-1:0] + sub. Registers the slice result, carry, sub and the remaining upper operand bits (b already inverted when sub=1).
- Stage k (1..STAGES-1): computes slice k from the registered upper operand bits plus the stage k−1 carry. Earlier result slices pass through unchanged. Unused upper-operand bits are dropped per stage.
- Bubbles: a stage with valid=0 still advances when advance=1; its valid is propagated as 0. Data in empty stages is don't-care, but flags must not toggle out_valid.
- Latency: STAGES cycles from accept to out_valid for an unstalled pipe; throughput 1/cycle.
- Flags, computed in the last stage from the final slice:
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = full-result reduction NOR, registered with the result.
- STAGES=1 degenerates to a single registered full-width add/sub.
- Output held stable while out_valid && !out_ready. No result is dropped or duplicated.
- in_valid with in_ready=0: no state change; the upstream must hold its operands.
- Reset mid-operation: all in-flight operations are discarded; no partial output.

Optional Feature:
- Macro: ADDSUB_PIPE_SAT_EN.
- Defined:
  - Adds input port in_sat (1 bit), carried down the pipe with its operation.
  - When in_sat=1 and the result overflows: out_result clamps to 0x7FF…F (positive overflow, i.e. both operands' effective sign 0) or 0x800…0 (negative overflow). out_ovf is still 1; out_zero is recomputed on the clamped value.
  - out_cout is unaffected by clamping.
- Not defined: port absent; wrap-around result only.

Test Plan (WIDTH=16, STAGES=4, out_ready=1 unless stated):
- Sub 0x0005−0x0003 → after 4 cycles: result 0x0002, cout=1, borrow=0, ovf=0, zero=0, combine 0x10002. Then 0x0003−0x0005 → 0xFFFE, cout=0, borrow=1.
- Cross-slice carry: add 0x00FF+0x0001 → 0x0100. Add 0xFFFF+0x0001 → 0x0000, cout=1, zero=1, ovf=0.
- Overflow: add 0x7FFF+0x0001 → 0x8000, ovf=1. Sub 0x8000−0x0001 → 0x7FFF, ovf=1. With ADDSUB_PIPE_SAT_EN and in_sat=1: 0x7FFF and 0x8000 respectively.
- Back-to-back: 8 consecutive ops (alternating add/sub) → 8 correct results on consecutive cycles starting at cycle 4 after the first accept.
- Backpressure: out_ready=0 for 5 cycles with a full pipe → in_ready=0, outputs stable. On release, results emerge in order with none lost.
- Reset: assert rst_n=0 with 3 ops in flight → out_valid=0 immediately and all outputs 0. After release, the first new op's result is correct with latency 4.

Source files
------------

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/subtract: WIDTH is cut into STAGES slices, one resolved per stage,
// with the carry registered between stages. Define ADDSUB_PIPE_SAT_EN for per-op saturation (in_sat).
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
`ifdef ADDSUB_PIPE_SAT_EN
  input  logic             in_sat,
`endif
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_borrow,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [WIDTH:0]   out_combine
);
  localparam int SW = WIDTH / STAGES;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             borrow;
    logic             ovf;
    logic             zero;
  } rsp_t;

  logic            advance;
  logic [STAGES:1] vld_pipe;
  rsp_t            rsp_n, rsp_q;

  // One global enable: the whole pipe moves only when the output slot can drain.
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];

  if (STAGES == 1) begin : vsh
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)       vld_pipe <= '0;
      else if (advance) vld_pipe <= in_valid;
  end else begin : vsh
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)       vld_pipe <= '0;
      else if (advance) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // Stages 0..STAGES-2: resolve one slice, forward the still-unused upper operand bits.
  genvar k;
  for (k = 0; k < STAGES-1; k++) begin : mid
    localparam int IW = WIDTH - k*SW;
    localparam int RW = (k+1)*SW;
    logic [IW-1:0]    a_s, b_s;
    logic             c_s, sub_s;
    logic [RW-1:0]    res_s;
    logic [SW:0]      sum;
    logic [IW-SW-1:0] a_q, b_q;
    logic             c_q, sub_q;
    logic [RW-1:0]    res_q;
`ifdef ADDSUB_PIPE_SAT_EN
    logic             sat_s, sat_q;
`endif

    if (k == 0) begin : src
      assign a_s   = in_a;
      assign b_s   = in_b ^ {WIDTH{in_sub}};
      assign c_s   = in_sub;
      assign sub_s = in_sub;
      assign res_s = sum[SW-1:0];
`ifdef ADDSUB_PIPE_SAT_EN
      assign sat_s = in_sat;
`endif
    end else begin : src
      assign a_s   = mid[k-1].a_q;
      assign b_s   = mid[k-1].b_q;
      assign c_s   = mid[k-1].c_q;
      assign sub_s = mid[k-1].sub_q;
      assign res_s = {sum[SW-1:0], mid[k-1].res_q};
`ifdef ADDSUB_PIPE_SAT_EN
      assign sat_s = mid[k-1].sat_q;
`endif
    end

    assign sum = {1'b0, a_s[SW-1:0]} + {1'b0, b_s[SW-1:0]} + {{SW{1'b0}}, c_s};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q   <= '0;
        b_q   <= '0;
        c_q   <= 1'b0;
        sub_q <= 1'b0;
        res_q <= '0;
`ifdef ADDSUB_PIPE_SAT_EN
        sat_q <= 1'b0;
`endif
      end else if (advance) begin
        a_q   <= a_s[IW-1:SW];
        b_q   <= b_s[IW-1:SW];
        c_q   <= sum[SW];
        sub_q <= sub_s;
        res_q <= res_s;
`ifdef ADDSUB_PIPE_SAT_EN
        sat_q <= sat_s;
`endif
      end
    end
  end

  // Last stage: top slice plus flags.
  logic [WIDTH-1:0] fres;
  logic             fcout, fa_msb, fb_msb, fsub;
`ifdef ADDSUB_PIPE_SAT_EN
  logic             fsat;
`endif

  if (STAGES == 1) begin : fin
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    assign b_eff  = in_b ^ {WIDTH{in_sub}};
    assign sum    = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, in_sub};
    assign fres   = sum[WIDTH-1:0];
    assign fcout  = sum[WIDTH];
    assign fa_msb = in_a[WIDTH-1];
    assign fb_msb = b_eff[WIDTH-1];
    assign fsub   = in_sub;
`ifdef ADDSUB_PIPE_SAT_EN
    assign fsat   = in_sat;
`endif
  end else begin : fin
    logic [SW:0] sum;
    assign sum    = {1'b0, mid[STAGES-2].a_q} + {1'b0, mid[STAGES-2].b_q}
                  + {{SW{1'b0}}, mid[STAGES-2].c_q};
    assign fres   = {sum[SW-1:0], mid[STAGES-2].res_q};
    assign fcout  = sum[SW];
    assign fa_msb = mid[STAGES-2].a_q[SW-1];
    assign fb_msb = mid[STAGES-2].b_q[SW-1];
    assign fsub   = mid[STAGES-2].sub_q;
`ifdef ADDSUB_PIPE_SAT_EN
    assign fsat   = mid[STAGES-2].sat_q;
`endif
  end

  logic ovf;
  logic [WIDTH-1:0] res_f;

  always_comb begin
    // carry into MSB is a^b^r at the MSB; overflow when it differs from carry out
    ovf   = fa_msb ^ fb_msb ^ fres[WIDTH-1] ^ fcout;
    res_f = fres;
`ifdef ADDSUB_PIPE_SAT_EN
    if (fsat && ovf)
      res_f = fa_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    rsp_n.result = res_f;
    rsp_n.cout   = fcout;
    rsp_n.borrow = fsub & ~fcout;
    rsp_n.ovf    = ovf;
    rsp_n.zero   = ~|res_f;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       rsp_q <= '0;
    else if (advance) rsp_q <= rsp_n;

  assign out_result  = rsp_q.result;
  assign out_cout    = rsp_q.cout;
  assign out_borrow  = rsp_q.borrow;
  assign out_ovf     = rsp_q.ovf;
  assign out_zero    = rsp_q.zero;
  assign out_combine = {rsp_q.cout, rsp_q.result};

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe (16-bit, 4 stages): directed and random ops scored against an arithmetic model.
module tb_addsub_pipe;
  localparam int W  = 16;
  localparam int ST = 4;
`ifdef ADDSUB_PIPE_SAT_EN
  localparam bit HAS_SAT = 1'b1;
`else
  localparam bit HAS_SAT = 1'b0;
`endif

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_sub = 1'b0, in_sat = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_ready, out_valid, out_cout, out_borrow, out_ovf, out_zero;
  logic [W-1:0] out_result;
  logic [W:0]   out_combine;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
`ifdef ADDSUB_PIPE_SAT_EN
    .in_sat(in_sat),
`endif
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cout(out_cout), .out_borrow(out_borrow),
    .out_ovf(out_ovf), .out_zero(out_zero), .out_combine(out_combine));

  typedef struct {
    logic [W-1:0] res;
    bit           cout, borrow, ovf, zero;
    int           cyc;
    bit           kv;
    logic [W:0]   k;
  } exp_t;

  typedef struct {
    bit sub; logic [W-1:0] a, b; bit sat; logic [W:0] k;
  } dir_t;

  exp_t       q[$];
  int         checks = 0, errors = 0, cyc = 0;
  bit         chk_lat = 0, last_acc = 0, snap_v = 0, kv_next = 0;
  logic [W:0] snap, k_next;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic, no bit-slicing.
  function automatic exp_t model(bit sub, logic [W-1:0] a, logic [W-1:0] b, bit sat);
    exp_t   e;
    longint m = longint'(1) << W;
    longint ua = longint'(a), ub = longint'(b);
    longint sa = a[W-1] ? ua - m : ua;
    longint sb = b[W-1] ? ub - m : ub;
    longint full, ssum, r;
    if (sub) begin full = ua - ub; e.cout = (ua >= ub); ssum = sa - sb; end
    else     begin full = ua + ub; e.cout = (full >= m); ssum = sa + sb; end
    r = ((full % m) + m) % m;
    e.ovf = (ssum > m/2 - 1) || (ssum < -(m/2));
    if (HAS_SAT && sat && e.ovf) r = (ssum > 0) ? m/2 - 1 : m/2;
    e.res    = r[W-1:0];
    e.zero   = (r == 0);
    e.borrow = sub && !e.cout;
    e.cyc = 0; e.kv = 0; e.k = '0;
    return e;
  endfunction

  // One cycle: score output and accept at negedge, then advance to posedge+1.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (snap_v) chk("hold_stable", out_combine, snap);
    snap_v = out_valid && !out_ready;
    snap   = out_combine;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("result", out_result, e.res);
        chk("cout", out_cout, e.cout);
        chk("borrow", out_borrow, e.borrow);
        chk("ovf", out_ovf, e.ovf);
        chk("zero", out_zero, e.zero);
        chk("combine", out_combine, {e.cout, e.res});
        if (chk_lat) chk("latency", cyc - e.cyc, ST);
        if (e.kv) chk("known_combine", out_combine, e.k);
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      e = model(in_sub, in_a, in_b, in_sat);
      e.cyc = cyc; e.kv = kv_next; e.k = k_next;
      q.push_back(e);
    end
    @(posedge clk); cyc++; #1;
  endtask

  task automatic set_op(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b, input bit sat);
    in_sub = sub; in_a = a; in_b = b; in_sat = sat; in_valid = 1'b1;
  endtask

  task automatic issue(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b, input bit sat);
    bit ok = 0;
    set_op(sub, a, b, sat);
    for (int i = 0; i < 20 && !ok; i++) begin step(); ok = last_acc; end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 60 && q.size() > 0; i++) step();
    chk("drain_empty", q.size(), 0);
    chk("idle_valid", out_valid, 0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] c[5];
    c[0] = '0; c[1] = 16'h0001; c[2] = 16'h7FFF; c[3] = 16'h8000; c[4] = 16'hFFFF;
    return ($urandom_range(0, 3) == 0) ? c[$urandom_range(0, 4)] : W'($urandom);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    dir_t dv[8];
    bit   pend;
    dv[0] = '{1, 16'h0005, 16'h0003, 0, 17'h10002};
    dv[1] = '{1, 16'h0003, 16'h0005, 0, 17'h0FFFE};
    dv[2] = '{0, 16'h00FF, 16'h0001, 0, 17'h00100};
    dv[3] = '{0, 16'hFFFF, 16'h0001, 0, 17'h10000};
    dv[4] = '{0, 16'h7FFF, 16'h0001, 0, 17'h08000};
    dv[5] = '{1, 16'h8000, 16'h0001, 0, 17'h17FFF};
    dv[6] = '{0, 16'h7FFF, 16'h0001, 1, HAS_SAT ? 17'h07FFF : 17'h08000};
    dv[7] = '{1, 16'h8000, 16'h0001, 1, HAS_SAT ? 17'h18000 : 17'h17FFF};

    // reset state
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_flags", {out_cout, out_borrow, out_ovf, out_zero}, 0);
    chk("rst_combine", out_combine, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // directed vectors, one at a time, fixed latency
    chk_lat = 1;
    foreach (dv[i]) begin
      kv_next = 1; k_next = dv[i].k;
      issue(dv[i].sub, dv[i].a, dv[i].b, dv[i].sat);
      kv_next = 0;
      drain();
    end

    // back-to-back alternating add/sub
    for (int i = 0; i < 8; i++) issue(i[0], W'($urandom), W'($urandom), 0);
    drain();

    // backpressure with a full pipe
    chk_lat = 0;
    out_ready = 1'b0;
    for (int i = 0; i < ST; i++) issue(1'($urandom), pick(), pick(), 1'($urandom));
    set_op(1'($urandom), pick(), pick(), 1'($urandom));
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_accept", last_acc, 1);
    drain();

    // reset with operations in flight
    chk_lat = 1;
    for (int i = 0; i < 4; i++) issue(1'($urandom), pick(), pick(), 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_combine", out_combine, 0);
    chk("mid_rst_flags", {out_borrow, out_ovf, out_zero}, 0);
    q.delete();
    snap_v = 0;
    @(posedge clk); cyc++; #1;
    rst_n = 1'b1;
    kv_next = 1; k_next = 17'h10002;
    issue(1, 16'h0005, 16'h0003, 0);
    kv_next = 0;
    drain();

    // random traffic with random backpressure
    chk_lat = 0;
    pend = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        in_sub = 1'($urandom); in_a = pick(); in_b = pick(); in_sat = 1'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      pend = in_valid && !last_acc;
    end
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
